// File: rtl/addr4u_residue_chk_pkg.sv
// Shared types, widths and mod-3 helper for the residue-checked 4-bit adder stage.
package addr4u_pkg;

    localparam int ADDR_W = 4;
    localparam int SUM_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } addr4u_state_t;

    // Adds two residues (each 0..2) and reduces the result (0..4) back to 0..2.
    function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        mod3_add = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/addr4u_residue_chk_if.sv
// Operand-in / result-out handshake bundle of the residue-check stage.
interface addr4u_residue_chk_if;
    import addr4u_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] a_in;
    logic [ADDR_W-1:0] b_in;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic              out_err;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );

endinterface

// File: rtl/addr4u_residue_chk_mod3_res.sv
// Combinational N-bit to 2-bit mod-3 residue: bit i weighs 1 (even i) or 2 (odd i), since 2^i mod 3 alternates.
module mod3_res
    import addr4u_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] value,
    output logic [1:0]   res
);

    logic [1:0] acc [0:N];

    assign acc[0] = 2'd0;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        localparam logic [1:0] WEIGHT = (gi % 2 == 0) ? 2'd1 : 2'd2;
        assign acc[gi+1] = value[gi] ? mod3_add(acc[gi], WEIGHT) : acc[gi];
    end

    assign res = acc[N];

endmodule

// File: rtl/addr4u_residue_chk.sv
// Operand issue / result check around an external 4-bit adder: residue-checks the sum, retries to filter transients.
module addr4u_residue_chk
    import addr4u_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    addr4u_residue_chk_if.slave  bus,
    output logic [ADDR_W-1:0]    op_a,
    output logic [ADDR_W-1:0]    op_b,
    input  logic [SUM_W-1:0]     sum_in,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     trans_cnt
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    addr4u_state_t      state_reg, state_next;
    logic [RETRY_W-1:0] retry_cnt_reg;
    logic               fail_reg;
    logic [ADDR_W-1:0]  op_a_reg, op_b_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   err_cnt_reg, trans_cnt_reg;

    logic [1:0] res_a, res_b, res_s, res_exp;
    logic       ok;
    logic       retry_left;

    mod3_res #(.N(ADDR_W)) u_res_a (.value(op_a_reg), .res(res_a));
    mod3_res #(.N(ADDR_W)) u_res_b (.value(op_b_reg), .res(res_b));
    mod3_res #(.N(SUM_W))  u_res_s (.value(sum_in),   .res(res_s));

    assign res_exp    = mod3_add(res_a, res_b);
    assign ok         = (res_s == res_exp);
    assign retry_left = (retry_cnt_reg < RETRY_W'(MAX_RETRY));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = EVAL;
            EVAL:    state_next = CHECK;
            CHECK: begin
                if (ok || !retry_left) state_next = DONE;
                else                   state_next = EVAL;
            end
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are masked during reset so nothing is offered or accepted in that cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        if (!rst) begin
            bus.in_ready  = (state_reg == IDLE);
            bus.out_valid = (state_reg == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_reg <= '0;
            fail_reg      <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            sum_reg       <= '0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
            trans_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a_reg      <= bus.a_in;
                        op_b_reg      <= bus.b_in;
                        retry_cnt_reg <= '0;
                        fail_reg      <= 1'b0;
                    end
                end
                CHECK: begin
                    sum_reg <= sum_in;
                    if (ok) begin
                        err_reg <= 1'b0;
                        if (fail_reg) trans_cnt_reg <= sat_inc(trans_cnt_reg);
                    end else if (retry_left) begin
                        retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                        fail_reg      <= 1'b1;
                    end else begin
                        err_reg     <= 1'b1;
                        err_cnt_reg <= sat_inc(err_cnt_reg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_a        = op_a_reg;
    assign op_b        = op_b_reg;
    assign bus.out_sum = sum_reg;
    assign bus.out_err = err_reg;
    assign err_cnt     = err_cnt_reg;
    assign trans_cnt   = trans_cnt_reg;

endmodule

// File: tb/tb_addr4u_residue_chk.sv
// Directed-vector bench for addr4u_residue_chk; the bench plays the external adder, with optional fault injection.
module tb_addr4u_residue_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op_a, op_b;
    logic [4:0] sum_in;
    logic [7:0] err_cnt, trans_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addr4u_residue_chk_if bus ();

    addr4u_residue_chk #(.MAX_RETRY(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .op_a      (op_a),
        .op_b      (op_b),
        .sum_in    (sum_in),
        .err_cnt   (err_cnt),
        .trans_cnt (trans_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accepts a/b and plays the adder: sum_in = bad for the first nbad CHECK cycles, then good.
    // Returns at the negedge where out_valid is first seen; lat counts cycles from the accept edge.
    task automatic run_to_done(input logic [3:0] a, input logic [3:0] b,
                               input logic [4:0] good, input logic [4:0] bad,
                               input int nbad, output int lat);
        @(negedge clk);
        check("in_ready_pre", bus.in_ready, 1);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        sum_in       = (nbad > 0) ? bad : good;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            sum_in = (lat < 2 * nbad + 1) ? bad : good;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) check("timeout", 0, 1);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
    endtask

    task automatic do_txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] good, input logic [4:0] bad, input int nbad,
                          input logic [4:0] exp_sum, input logic exp_err, input int exp_lat);
        int lat;
        run_to_done(a, b, good, bad, nbad, lat);
        check({tag, "_sum"}, bus.out_sum, exp_sum);
        check({tag, "_err"}, bus.out_err, exp_err);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_op_a"}, op_a, a);
        check({tag, "_op_b"}, op_b, b);
        $display("txn %s a=%0d b=%0d sum=%0d err=%0d lat=%0d err_cnt=%0d trans_cnt=%0d",
                 tag, a, b, bus.out_sum, bus.out_err, lat, err_cnt, trans_cnt);
        release_result();
    endtask

    // Starts a transaction and pulses rst in the cycle 'stop_n' after the accept edge.
    task automatic reset_mid(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [4:0] s, input int stop_n, input logic exp_valid);
        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        sum_in       = s;
        @(posedge clk);
        for (int i = 0; i < stop_n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        check({tag, "_valid_pre"}, bus.out_valid, exp_valid);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_ready_in_rst"}, bus.in_ready, 0);
        check({tag, "_valid_in_rst"}, bus.out_valid, 0);
        rst = 1'b0;
        #1;
        check({tag, "_ready"}, bus.in_ready, 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_trans_cnt"}, trans_cnt, 0);
        check({tag, "_op_a"}, op_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_no_valid"}, bus.out_valid, 0);
        end
        $display("txn %s a=%0d b=%0d reset after %0d cycles", tag, a, b, stop_n);
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        sum_in        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_trans_cnt", trans_cnt, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", bus.in_ready, 1);

        do_txn("clean", 4'd7, 4'd9, 5'd16, 5'd16, 0, 5'd16, 1'b0, 3);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_trans_cnt", trans_cnt, 0);

        do_txn("transient", 4'd7, 4'd9, 5'd16, 5'd17, 1, 5'd16, 1'b0, 5);
        check("transient_trans_cnt", trans_cnt, 1);
        check("transient_err_cnt", err_cnt, 0);

        do_txn("persist", 4'd5, 4'd6, 5'd11, 5'd12, 100, 5'd12, 1'b1, 7);
        check("persist_err_cnt", err_cnt, 1);
        check("persist_trans_cnt", trans_cnt, 1);

        // Backpressure: result held while out_ready=0; in_valid in DONE must not load operands.
        run_to_done(4'd3, 4'd4, 5'd7, 5'd7, 0, lat);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a_in     = 4'd1;
            bus.b_in     = 4'd2;
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_sum", bus.out_sum, 7);
            check("bp_err", bus.out_err, 0);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_op_a", op_a, 3);
        end
        bus.in_valid = 1'b0;
        $display("txn backpressure a=3 b=4 sum=%0d held 4 cycles", bus.out_sum);
        release_result();
        check("bp_op_a_after", op_a, 3);

        reset_mid("rst_check", 4'd2, 4'd3, 5'd5, 2, 1'b0);
        do_txn("persist2", 4'd5, 4'd6, 5'd11, 5'd12, 100, 5'd12, 1'b1, 7);
        check("persist2_err_cnt", err_cnt, 1);
        reset_mid("rst_done", 4'd5, 4'd6, 5'd12, 7, 1'b1);

        for (int i = 0; i < 255; i++)
            do_txn("sat", 4'd5, 4'd6, 5'd11, 5'd12, 100, 5'd12, 1'b1, 7);
        check("sat_err_cnt_255", err_cnt, 255);
        do_txn("sat_extra", 4'd5, 4'd6, 5'd11, 5'd12, 100, 5'd12, 1'b1, 7);
        check("sat_err_cnt_hold", err_cnt, 255);

        // 15+15=30 but 27 differs by 3: invisible to a mod-3 check.
        do_txn("undetect", 4'd15, 4'd15, 5'd27, 5'd27, 0, 5'd27, 1'b0, 3);
        check("undetect_err_cnt", err_cnt, 255);
        check("undetect_trans_cnt", trans_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
